// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
//
// Two-client arbiter and access sequencer for a single-port synchronous RAM.
// It accepts one read or write from client A or client B and grants the
// requests one at a time under round-robin priority. For each grant it drives
// the RAM for exactly one access cycle. It then returns a one-cycle acknowledge
// to the granted client, together with the read data. The RAM is always run in
// synchronous-read mode.
//
// Parameters
//   DW        data width (must match the RAM)
//   AW        address width (must match the RAM)
//
// Ports
//   clk       clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   req_a/b   client request, held high until the matching ack
//   we_a/b    1 = write, 0 = read, sampled with req
//   addr_a/b  client access address
//   wdata_a/b client write data
//   ack_a/b   one-cycle completion pulse
//   rdata_a/b read data, forced to 0 whenever the matching ack is low
//   busy      high whenever an access is in flight (not IDLE)
//   ram_cs    RAM chip select
//   ram_we    RAM write enable
//   ram_oe    RAM output enable
//   ram_mode  RAM mode select, tied to 1 (synchronous read)
//   ram_addr  RAM address, holds the last latched value outside ACCESS
//   ram_din   RAM write data, holds the last latched value outside ACCESS
//   ram_dout  RAM read data
// -----------------------------------------------------------------------------
module sp_ram_arbiter #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,

  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,

  output logic          busy,

  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_oe,
  output logic          ram_mode,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // prio_b = 1 means client B wins the next contended grant.
  logic prio_b;

  // Transaction captured at the grant and replayed to the RAM.
  // gnt_b selects which client receives the ack.
  logic          gnt_b;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_din;

  logic grant;
  logic grant_b;

  // State register. When reset is asserted, the state returns to IDLE at once.
  // This drops cs before the next edge, so an in-flight write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. Every output depends only on registered
  // state. The exception is rdata, which passes ram_dout through but is gated
  // by the registered ack.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_b    = 1'b0;
    busy       = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    ack_a      = 1'b0;
    ack_b      = 1'b0;
    rdata_a    = '0;
    rdata_b    = '0;

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant      = 1'b1;
          // B wins only when it is the sole requester, or when it holds priority.
          grant_b    = req_b && (!req_a || prio_b);
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        busy       = 1'b1;
        ram_cs     = 1'b1;
        ram_we     = lat_we;
        ram_oe     = !lat_we;
        state_next = DONE;
      end

      DONE: begin
        busy       = 1'b1;
        ack_a      = !gnt_b;
        ack_b      = gnt_b;
        if (!gnt_b) begin
          rdata_a = ram_dout;
        end else begin
          rdata_b = ram_dout;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Priority register. Each grant hands priority to the client that was not
  // granted, so the grants alternate when both clients keep requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (grant) begin
      prio_b <= !grant_b;
    end
  end

  // Capture the granted client's request fields. Changes to the client
  // inputs after this point have no effect until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_b    <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
    end else if (grant) begin
      gnt_b    <= grant_b;
      lat_we   <= grant_b ? we_b    : we_a;
      lat_addr <= grant_b ? addr_b  : addr_a;
      lat_din  <= grant_b ? wdata_b : wdata_a;
    end
  end

  assign ram_addr = lat_addr;
  assign ram_din  = lat_din;
  assign ram_mode = 1'b1;

endmodule
